// File: rtl/iob_cache_arb_pkg.sv
// Shared definitions for the cache front-end arbiter: FSM encoding and
// a small modular-index helper used by the round-robin picker.
package iob_cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        WAIT_R = 2'd2
    } arb_state_t;

    // (base + off) mod n, valid for base < n and off < n
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/iob_cache_rr_sel.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module iob_cache_rr_sel
    import iob_cache_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] sel,
    output logic             any
);

    logic [N-1:0]     rot;
    logic [SEL_W-1:0] pos;
    logic [SEL_W-1:0] src;

    always_comb begin
        rot = '0;
        src = '0;
        for (int i = 0; i < N; i++) begin
            src    = SEL_W'(wrap_idx(int'(ptr), i, N));
            rot[i] = req[src];
        end
    end

    // Descending scan so the lowest rotated index wins.
    always_comb begin
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pos = SEL_W'(i);
        end
    end

    assign any = |req;
    assign sel = SEL_W'(wrap_idx(int'(ptr), int'(pos), N));

endmodule

// File: rtl/iob_cache_front_arb.sv
// Round-robin arbiter sharing one cache front-end IOb port between N masters,
// one outstanding transaction at a time; read grants last until rvalid.
module iob_cache_front_arb
    import iob_cache_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SEL_W     = $clog2(N_MASTERS)
) (
    input  logic                            clk_i,
    input  logic                            arst_n_i,
    input  logic                            cke_i,
    input  logic [N_MASTERS-1:0]            m_valid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb_i,
    output logic [N_MASTERS-1:0]            m_ready_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    output logic                            s_valid_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    output logic [DATA_W/8-1:0]             s_wstrb_o,
    input  logic                            s_ready_i,
    input  logic                            s_rvalid_i,
    input  logic [DATA_W-1:0]               s_rdata_i
);

    localparam int               STRB_W = DATA_W / 8;
    localparam logic [SEL_W-1:0] LAST   = SEL_W'(N_MASTERS - 1);

    arb_state_t       state, state_nxt;
    logic [SEL_W-1:0] sel, sel_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] sel_inc;
    logic             pick_any;
    logic             req_v;
    logic             is_write;

    iob_cache_rr_sel #(
        .N     (N_MASTERS),
        .SEL_W (SEL_W)
    ) u_rr_sel (
        .req (m_valid_i),
        .ptr (ptr),
        .sel (pick),
        .any (pick_any)
    );

    // Slave-side request fields always follow sel; only valid is gated by state.
    assign s_addr_o  = m_addr_i[sel*ADDR_W +: ADDR_W];
    assign s_wdata_o = m_wdata_i[sel*DATA_W +: DATA_W];
    assign s_wstrb_o = m_wstrb_i[sel*STRB_W +: STRB_W];
    assign m_rdata_o = s_rdata_i;

    assign req_v    = m_valid_i[sel];
    assign is_write = |s_wstrb_o;
    assign sel_inc  = (sel == LAST) ? '0 : sel + SEL_W'(1);

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        ptr_nxt    = ptr;
        s_valid_o  = 1'b0;
        m_ready_o  = '0;
        m_rvalid_o = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    sel_nxt   = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                s_valid_o = req_v;
                if (req_v) begin
                    m_ready_o[sel] = s_ready_i;
                    if (s_ready_i) begin
                        if (is_write) begin
                            state_nxt = IDLE;
                            ptr_nxt   = sel_inc;
                        end else begin
                            state_nxt = WAIT_R;
                        end
                    end
                end else begin
                    // Master withdrew before acceptance: drop the grant, issue nothing.
                    state_nxt = IDLE;
                    ptr_nxt   = sel_inc;
                end
            end
            WAIT_R: begin
                if (s_rvalid_i) begin
                    m_rvalid_o[sel] = 1'b1;
                    state_nxt       = IDLE;
                    ptr_nxt         = sel_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else if (cke_i) begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_iob_cache_front_arb.sv
// Self-checking bench for iob_cache_front_arb: directed vector table,
// hand-written stall/fairness sequences and a randomized run against a model.
module tb_iob_cache_front_arb;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int STW = DW / 8;

    logic              clk_i = 1'b0;
    logic              arst_n_i;
    logic              cke_i;
    logic [N-1:0]      m_valid_i;
    logic [N*AW-1:0]   m_addr_i;
    logic [N*DW-1:0]   m_wdata_i;
    logic [N*STW-1:0]  m_wstrb_i;
    logic [N-1:0]      m_ready_o;
    logic [N-1:0]      m_rvalid_o;
    logic [DW-1:0]     m_rdata_o;
    logic              s_valid_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_wdata_o;
    logic [STW-1:0]    s_wstrb_o;
    logic              s_ready_i;
    logic              s_rvalid_i;
    logic [DW-1:0]     s_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level reference: who owns the port, whether a read is pending,
    // and where the next round-robin scan starts.
    bit mdl_busy;
    bit mdl_rd;
    int mdl_own;
    int mdl_next;

    iob_cache_front_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .cke_i      (cke_i),
        .m_valid_i  (m_valid_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_wstrb_i  (m_wstrb_i),
        .m_ready_o  (m_ready_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .s_valid_o  (s_valid_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_wstrb_o  (s_wstrb_o),
        .s_ready_i  (s_ready_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] valid;
        logic [1:0] wr;
        logic       sr;
        logic       rv;
        logic [1:0] e_ready;
        logic       e_sv;
        logic [1:0] e_rv;
        int         e_sel;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_busy = 0;
        mdl_rd   = 0;
        mdl_own  = 0;
        mdl_next = 0;
    endtask

    task automatic mdl_release();
        mdl_busy = 0;
        mdl_rd   = 0;
        mdl_next = (mdl_own + 1) % N;
    endtask

    task automatic mdl_step();
        if (!mdl_busy) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mdl_next + k) % N;
                if (!mdl_busy && m_valid_i[c]) begin
                    mdl_busy = 1;
                    mdl_own  = c;
                end
            end
        end else if (!mdl_rd) begin
            if (m_valid_i[mdl_own] && s_ready_i) begin
                if (m_wstrb_i[mdl_own*STW +: STW] != '0) mdl_release();
                else mdl_rd = 1;
            end else if (!m_valid_i[mdl_own]) begin
                mdl_release();
            end
        end else if (s_rvalid_i) begin
            mdl_release();
        end
    endtask

    // Inputs are driven at posedge+1; outputs are sampled at the falling edge.
    task automatic settle();
        #4;
        if (!arst_n_i) mdl_reset();
    endtask

    task automatic adv();
        @(posedge clk_i);
        if (!arst_n_i) mdl_reset();
        else if (cke_i) mdl_step();
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [N-1:0] er, ev;
        logic         es;
        es = mdl_busy && !mdl_rd && m_valid_i[mdl_own];
        er = '0;
        ev = '0;
        if (es && s_ready_i) er[mdl_own] = 1'b1;
        if (mdl_busy && mdl_rd && s_rvalid_i) ev[mdl_own] = 1'b1;
        chk({tag, ".s_valid"}, 32'(s_valid_o), 32'(es));
        chk({tag, ".m_ready"}, 32'(m_ready_o), 32'(er));
        chk({tag, ".m_rvalid"}, 32'(m_rvalid_o), 32'(ev));
        chk({tag, ".s_addr"}, s_addr_o, m_addr_i[mdl_own*AW +: AW]);
        chk({tag, ".s_wdata"}, s_wdata_o, m_wdata_i[mdl_own*DW +: DW]);
        chk({tag, ".s_wstrb"}, 32'(s_wstrb_o), 32'(m_wstrb_i[mdl_own*STW +: STW]));
        chk({tag, ".m_rdata"}, m_rdata_o, s_rdata_i);
    endtask

    task automatic set_wr(input logic [1:0] wr);
        m_wstrb_i = {(wr[1] ? 4'hF : 4'h0), (wr[0] ? 4'hF : 4'h0)};
    endtask

    task automatic do_reset();
        arst_n_i = 1'b0;
        settle();
        adv();
        arst_n_i = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] ea;
        int            got[$];
        int            cyc;
        int            cnt0;

        mdl_reset();
        arst_n_i   = 1'b0;
        cke_i      = 1'b1;
        m_valid_i  = 2'b11;
        m_addr_i   = {32'h0000_0040, 32'h0000_1000};
        m_wdata_i  = {32'h1111_1111, 32'h0000_0000};
        m_wstrb_i  = '0;
        s_ready_i  = 1'b1;
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'h0;
        #1;

        // Reset held with both masters requesting: nothing moves.
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst.s_valid", 32'(s_valid_o), 32'h0);
            chk("rst.m_ready", 32'(m_ready_o), 32'h0);
            chk("rst.m_rvalid", 32'(m_rvalid_o), 32'h0);
            chk("rst.s_addr", s_addr_o, 32'h0000_1000);
            adv();
        end
        arst_n_i   = 1'b1;
        s_rvalid_i = 1'b0;
        settle(); chk_model("rel0"); adv();
        settle(); chk_model("rel1");
        chk("rel.first_grant", 32'(m_ready_o), 32'h1);
        adv();
        s_rvalid_i = 1'b1;
        settle(); chk_model("rel2"); adv();
        s_rvalid_i = 1'b0;
        m_valid_i  = 2'b00;
        do_reset();

        // Directed vectors, starting from ptr=0 / sel=0.
        tbl[0]  = '{2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 0};
        tbl[1]  = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 1};
        tbl[2]  = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b10, 1};
        tbl[3]  = '{2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1};
        tbl[4]  = '{2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00, 0};
        tbl[5]  = '{2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 0};
        tbl[6]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 0};
        tbl[7]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1};
        tbl[8]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 1};
        tbl[9]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1};
        tbl[10] = '{2'b11, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b10, 1};
        tbl[11] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1};
        tbl[12] = '{2'b10, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 0};
        tbl[13] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 0};
        tbl[14] = '{2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 1};
        tbl[15] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1};

        for (int r = 0; r < 16; r++) begin
            m_valid_i  = tbl[r].valid;
            set_wr(tbl[r].wr);
            s_ready_i  = tbl[r].sr;
            s_rvalid_i = tbl[r].rv;
            s_rdata_i  = (r == 2) ? 32'hDEAD_BEEF : 32'(r);
            settle();
            ea = m_addr_i[tbl[r].e_sel*AW +: AW];
            chk($sformatf("vec%0d.m_ready", r), 32'(m_ready_o), 32'(tbl[r].e_ready));
            chk($sformatf("vec%0d.s_valid", r), 32'(s_valid_o), 32'(tbl[r].e_sv));
            chk($sformatf("vec%0d.m_rvalid", r), 32'(m_rvalid_o), 32'(tbl[r].e_rv));
            chk($sformatf("vec%0d.s_addr", r), s_addr_o, ea);
            if (r == 2) chk("vec2.m_rdata", m_rdata_o, 32'hDEAD_BEEF);
            adv();
        end

        // Slave stall: M0 granted, ready low 5 cycles, M1 also waiting.
        m_valid_i  = 2'b11;
        set_wr(2'b00);
        s_ready_i  = 1'b0;
        s_rvalid_i = 1'b0;
        settle(); adv();
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall.s_valid", 32'(s_valid_o), 32'h1);
            chk("stall.s_addr", s_addr_o, 32'h0000_1000);
            chk("stall.m_ready", 32'(m_ready_o), 32'h0);
            adv();
        end
        s_ready_i = 1'b1;
        settle();
        chk("stall.accept", 32'(m_ready_o), 32'h1);
        adv();
        s_ready_i  = 1'b0;
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'hCAFE_0001;
        settle();
        chk("stall.rvalid", 32'(m_rvalid_o), 32'h1);
        chk("stall.rdata", m_rdata_o, 32'hCAFE_0001);
        adv();

        // Fairness: both masters stream reads, slave answers one cycle after ready.
        s_ready_i  = 1'b1;
        s_rvalid_i = 1'b1;
        cyc = 0;
        while (got.size() < 8 && cyc < 100) begin
            settle();
            if (m_ready_o == 2'b01) got.push_back(0);
            else if (m_ready_o == 2'b10) got.push_back(1);
            adv();
            cyc++;
        end
        chk("fair.count", 32'(got.size()), 32'd8);
        cnt0 = 0;
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("fair.grant%0d", i), 32'(got[i]), 32'((i + 1) % 2));
            if (got[i] == 0) cnt0++;
        end
        chk("fair.m0_share", 32'(cnt0), 32'd4);
        s_ready_i  = 1'b0;
        s_rvalid_i = 1'b0;
        m_valid_i  = 2'b00;
        settle(); adv();
        settle(); adv();
        do_reset();
        mdl_reset();

        // Randomized run against the reference model, with cke gaps and resets.
        for (int i = 0; i < 3000; i++) begin
            arst_n_i   = ($urandom_range(0, 199) != 0);
            cke_i      = ($urandom_range(0, 9) != 0);
            m_valid_i  = N'($urandom);
            m_addr_i   = {$urandom, $urandom};
            m_wdata_i  = {$urandom, $urandom};
            for (int k = 0; k < N; k++)
                m_wstrb_i[k*STW +: STW] = $urandom_range(0, 1) ? STW'($urandom_range(1, 15)) : '0;
            s_ready_i  = 1'($urandom);
            s_rvalid_i = 1'($urandom);
            s_rdata_i  = $urandom;
            settle();
            chk_model("rnd");
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
